// File: rtl/vip_frame_writer.sv
// vip_frame_writer
// Receives an Avalon-ST Video stream and writes the pixels of each video
// packet into memory via an Avalon-MM write master. The master writes one
// 32-bit word per pixel, starting at a programmable base word address.
// Control packets update the frame width and height. Packets of any other
// type are consumed and discarded.
//
// Optional build macro: FRAME_WRITER_STATUS_EN
//   When defined, ctrl_read returns status with one cycle of latency.
//     address 0: {frame_cnt, err_cnt}
//     address 1: {height, width}
//   When undefined, ctrl_readdata is tied to 0.
//
// Ports
//   clk, reset_n         sole clock (rising edge); asynchronous active-low reset
//   st_data/valid/sop/eop, st_ready
//                        Avalon-ST Video sink with a ready latency of 1
//   address, writedata, write, waitrequest
//                        Avalon-MM write master; address is a word address
//   ctrl_chipselect/write/read/address/data, ctrl_readdata
//                        control slave
//                          write address 0: base
//                          write address 1: enable (ctrl_data[0])
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | between packets; valid beats without sop are ignored
// S_CTRL  | control packet; nibbles are latched by beat index
// S_VIDEO | video packet; pixels are pushed into the write FIFO
// S_DROP  | unknown packet type, or video while disabled; beats discarded
module vip_frame_writer #(
  parameter int VIDEO_W    = 1024,
  parameter int VIDEO_H    = 768,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [23:0] st_data,
  input  logic        st_valid,
  input  logic        st_sop,
  input  logic        st_eop,
  output logic        st_ready,
  output logic [31:0] address,
  output logic [31:0] writedata,
  output logic        write,
  input  logic        waitrequest,
  input  logic        ctrl_chipselect,
  input  logic        ctrl_write,
  input  logic        ctrl_read,
  input  logic        ctrl_address,
  input  logic [31:0] ctrl_data,
  output logic [31:0] ctrl_readdata
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_CTRL, S_VIDEO, S_DROP} state_t;

  state_t        state_q, state_d;
  logic          rdy_q, rdy_d1_q;
  logic [31:0]   base_q;
  logic          enable_q;
  logic [15:0]   width_q, height_q;
  logic [15:0]   tmp_w_q, tmp_w_d;
  logic [7:0]    tmp_h_q, tmp_h_d;
  logic [1:0]    cidx_q, cidx_d;
  logic [31:0]   pix_q, pix_d;
  logic [31:0]   waddr_q, waddr_d;
  logic [23:0]   dmem_q [FIFO_DEPTH];
  logic [31:0]   amem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          beat, push, pop, commit, frame_done, frame_short;
  logic [31:0]   area;

  // A beat is only legal in the cycle after st_ready was high.
  assign beat      = st_valid & rdy_d1_q;
  assign area      = 32'(width_q) * 32'(height_q);
  assign write     = (cnt_q != '0);
  // Each FIFO entry carries its own target address. A new frame can
  // therefore start while the previous frame is still draining.
  assign address   = amem_q[rptr_q];
  assign writedata = {8'h00, dmem_q[rptr_q]};
  assign pop       = write & ~waitrequest;
  assign cnt_d     = cnt_q + CW'(push) - CW'(pop);
  assign st_ready  = rdy_q;

  always_comb begin
    state_d     = state_q;
    tmp_w_d     = tmp_w_q;
    tmp_h_d     = tmp_h_q;
    cidx_d      = cidx_q;
    pix_d       = pix_q;
    waddr_d     = waddr_q;
    push        = 1'b0;
    commit      = 1'b0;
    frame_done  = 1'b0;
    frame_short = 1'b0;
    if (beat && st_sop) begin
      // A sop beat always starts a new packet; the current one is abandoned.
      cidx_d = 2'd0;
      pix_d  = '0;
      case (st_data[3:0])
        4'd0: begin
          if (enable_q) begin
            state_d = S_VIDEO;
            waddr_d = base_q;
          end else begin
            state_d = S_DROP;
          end
        end
        4'd15:   state_d = S_CTRL;
        default: state_d = S_DROP;
      endcase
    end else if (beat) begin
      case (state_q)
        S_CTRL: begin
          if (cidx_q != 2'd3) cidx_d = cidx_q + 2'd1;
          case (cidx_q)
            2'd0: tmp_w_d[15:4] = {st_data[3:0], st_data[11:8], st_data[19:16]};
            2'd1: begin
              tmp_w_d[3:0] = st_data[3:0];
              tmp_h_d      = {st_data[11:8], st_data[19:16]};
            end
            // Beat 3 completes the height. Its interlace nibble is not used
            // by this writer.
            2'd2:    commit = 1'b1;
            default: ;
          endcase
        end
        S_VIDEO: begin
          if (pix_q < area) begin
            push    = 1'b1;
            pix_d   = pix_q + 32'd1;
            waddr_d = waddr_q + 32'd1;
          end
          if (st_eop) begin
            if (pix_q + 32'd1 < area) frame_short = 1'b1;
            else                      frame_done  = 1'b1;
          end
        end
        default: ;
      endcase
    end
    if (beat && st_eop) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      rdy_q    <= 1'b0;
      rdy_d1_q <= 1'b0;
      base_q   <= '0;
      enable_q <= 1'b0;
      width_q  <= 16'(VIDEO_W);
      height_q <= 16'(VIDEO_H);
      tmp_w_q  <= '0;
      tmp_h_q  <= '0;
      cidx_q   <= '0;
      pix_q    <= '0;
      waddr_q  <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      // Counting this cycle's push leaves room for the beat that may still
      // arrive one cycle after st_ready drops.
      rdy_q    <= (cnt_d <= CW'(FIFO_DEPTH - 2));
      rdy_d1_q <= rdy_q;
      tmp_w_q  <= tmp_w_d;
      tmp_h_q  <= tmp_h_d;
      cidx_q   <= cidx_d;
      pix_q    <= pix_d;
      waddr_q  <= waddr_d;
      cnt_q    <= cnt_d;
      if (commit) begin
        width_q  <= tmp_w_q;
        height_q <= {tmp_h_q, st_data[3:0], st_data[11:8]};
      end
      if (ctrl_chipselect && ctrl_write) begin
        if (ctrl_address) enable_q <= ctrl_data[0];
        else              base_q   <= ctrl_data;
      end
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
    end
  end

  // The storage is reset so that address and writedata read 0 out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        dmem_q[i] <= '0;
        amem_q[i] <= '0;
      end
    end else if (push) begin
      dmem_q[wptr_q] <= st_data;
      amem_q[wptr_q] <= waddr_q;
    end
  end

`ifdef FRAME_WRITER_STATUS_EN
  logic [15:0] frame_cnt_q, err_cnt_q;
  logic [31:0] rdata_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
      rdata_q     <= '0;
    end else begin
      if (frame_done)  frame_cnt_q <= frame_cnt_q + 16'd1;
      if (frame_short) err_cnt_q   <= err_cnt_q + 16'd1;
      if (ctrl_chipselect && ctrl_read)
        rdata_q <= ctrl_address ? {height_q, width_q} : {frame_cnt_q, err_cnt_q};
    end
  end

  assign ctrl_readdata = rdata_q;
`else
  logic unused_status;
  assign unused_status = ^{ctrl_read, frame_done, frame_short};
  assign ctrl_readdata = '0;
`endif

endmodule

// File: tb/tb_vip_frame_writer.sv
module tb_vip_frame_writer;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [23:0] st_data;
  logic        st_valid, st_sop, st_eop, st_ready;
  logic [31:0] address, writedata;
  logic        write, waitrequest;
  logic        ctrl_chipselect, ctrl_write, ctrl_read, ctrl_address;
  logic [31:0] ctrl_data, ctrl_readdata;

  vip_frame_writer dut (
    .clk(clk), .reset_n(reset_n),
    .st_data(st_data), .st_valid(st_valid), .st_sop(st_sop), .st_eop(st_eop),
    .st_ready(st_ready),
    .address(address), .writedata(writedata), .write(write), .waitrequest(waitrequest),
    .ctrl_chipselect(ctrl_chipselect), .ctrl_write(ctrl_write), .ctrl_read(ctrl_read),
    .ctrl_address(ctrl_address), .ctrl_data(ctrl_data), .ctrl_readdata(ctrl_readdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // reference model
  int          m_w, m_h, m_frames, m_errs;
  logic [31:0] m_base;
  bit          m_en;
  logic [63:0] exp_q[$];
  logic [63:0] wlog[$];

  // driver / monitor shared state
  bit   tb_push;
  bit   rdy_prev, rdy_cur;
  int   wmode;
  int   wcnt;
  int   occ;
  bit   exp_rdy, hold_prev, rdy_low_seen;
  logic [31:0] hold_a, hold_d;
  logic [63:0] got, e;
  logic [31:0] rv;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
    rdy_prev = rdy_cur;
    rdy_cur  = st_ready;
    st_valid = 1'b0; st_sop = 1'b0; st_eop = 1'b0; tb_push = 1'b0;
    ctrl_chipselect = 1'b0; ctrl_write = 1'b0; ctrl_read = 1'b0;
  endtask

  task automatic ctrl_wr(input logic a, input logic [31:0] d);
    tick();
    ctrl_chipselect = 1'b1; ctrl_write = 1'b1; ctrl_address = a; ctrl_data = d;
    if (a) m_en = d[0];
    else   m_base = d;
  endtask

  task automatic ctrl_rd(input logic a, output logic [31:0] v);
    tick();
    ctrl_chipselect = 1'b1; ctrl_read = 1'b1; ctrl_address = a;
    tick();
    v = ctrl_readdata;
  endtask

  task automatic beat(input logic [23:0] d, input bit sop, input bit eop, input bit push);
    int n = 0;
    tick();
    while (!(rdy_prev && $urandom_range(0, 3) != 0)) begin
      n++;
      if (n > 2000) begin
        chk(1'b0, "beat_timeout", 64'(n), 0);
        return;
      end
      tick();
    end
    st_data = d; st_valid = 1'b1; st_sop = sop; st_eop = eop; tb_push = push;
  endtask

  task automatic send_ctrl(input logic [15:0] w, input logic [15:0] h, input int nb);
    logic [23:0] d;
    d = (24'($urandom) & 24'hFFFFF0) | 24'h00000F;
    beat(d, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= nb; i++) begin
      d = 24'($urandom);
      case (i)
        1: begin d[3:0] = w[15:12]; d[11:8] = w[11:8]; d[19:16] = w[7:4]; end
        2: begin d[3:0] = w[3:0];   d[11:8] = h[15:12]; d[19:16] = h[11:8]; end
        3: begin d[3:0] = h[7:4];   d[11:8] = h[3:0]; end
        default: ;
      endcase
      beat(d, 1'b0, i == nb, 1'b0);
    end
    if (nb >= 3) begin m_w = int'(w); m_h = int'(h); end
  endtask

  task automatic send_video(input int n, input bit seq, input logic [23:0] start, input bit abort);
    logic [31:0] a;
    logic [23:0] d;
    bit en, p;
    int area;
    en = m_en; a = m_base; area = m_w * m_h;
    beat(24'($urandom) & 24'hFFFFF0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      d = seq ? start + 24'(i) : 24'($urandom);
      p = en && (i < area);
      if (p) begin
        exp_q.push_back({a, 8'h00, d});
        a = a + 32'd1;
      end
      beat(d, 1'b0, !abort && (i == n - 1), p);
    end
    if (en && !abort) begin
      if (n < area) m_errs++;
      else          m_frames++;
    end
  endtask

  task automatic send_other(input logic [3:0] t, input int nb);
    beat({20'($urandom), t}, 1'b1, nb == 1, 1'b0);
    for (int i = 2; i <= nb; i++) beat(24'($urandom), 1'b0, i == nb, 1'b0);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 || write) begin
      tick();
      n++;
      if (n > 3000) begin
        chk(1'b0, "drain_timeout", 64'(exp_q.size()), 0);
        break;
      end
    end
    tick(); tick();
  endtask

  task automatic model_reset();
    exp_q.delete();
    tb_push = 1'b0; st_valid = 1'b0;
    rdy_prev = 1'b0; rdy_cur = 1'b0;
    m_w = 1024; m_h = 768; m_base = '0; m_en = 1'b0; m_frames = 0; m_errs = 0;
  endtask

  task automatic check_status();
`ifdef FRAME_WRITER_STATUS_EN
    ctrl_rd(1'b0, rv);
    chk(rv == {16'(m_frames), 16'(m_errs)}, "status_counts", rv, {16'(m_frames), 16'(m_errs)});
    ctrl_rd(1'b1, rv);
    chk(rv == {16'(m_h), 16'(m_w)}, "status_dims", rv, {16'(m_h), 16'(m_w)});
`else
    ctrl_rd(1'b0, rv);
    chk(rv == 32'h0, "status_tied_zero", rv, 0);
`endif
  endtask

  // waitrequest generator
  initial begin
    waitrequest = 1'b0;
    wcnt = 0;
    forever begin
      @(posedge clk); #1;
      case (wmode)
        0: waitrequest = ($urandom_range(0, 3) == 0);
        1: begin
          if (write) begin
            if (wcnt < 5) begin waitrequest = 1'b1; wcnt++; end
            else          begin waitrequest = 1'b0; wcnt = 0; end
          end else begin
            waitrequest = 1'b0; wcnt = 0;
          end
        end
        2: waitrequest = 1'b0;
        default: waitrequest = 1'b1;
      endcase
    end
  end

  // compare process: FIFO occupancy is tracked as beats pushed minus writes accepted
  always @(negedge clk) begin
    if (!reset_n) begin
      occ = 0; exp_rdy = 1'b0; hold_prev = 1'b0;
      chk(write == 1'b0, "rst_write", 64'(write), 0);
      chk(st_ready == 1'b0, "rst_st_ready", 64'(st_ready), 0);
    end else begin
      chk(st_ready == exp_rdy, "st_ready", 64'(st_ready), 64'(exp_rdy));
      chk(write == (occ > 0), "write_pending", 64'(write), 64'(occ > 0));
      if (hold_prev) begin
        chk(write == 1'b1, "hold_write", 64'(write), 1);
        chk(address == hold_a, "hold_addr", address, hold_a);
        chk(writedata == hold_d, "hold_data", writedata, hold_d);
      end
      if (!st_ready) rdy_low_seen = 1'b1;
      if (write && !waitrequest) begin
        got = {address, writedata};
        wlog.push_back(got);
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_write", got, 0);
        end else begin
          e = exp_q.pop_front();
          chk(got == e, "write_addr_data", got, e);
        end
        occ--;
      end
      if (tb_push) occ++;
      exp_rdy = (occ <= D - 2);
      hold_prev = write && waitrequest;
      hold_a = address;
      hold_d = writedata;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=%0t required=finish", $time);
    $fatal(1, "timeout");
  end

  initial begin
    st_data = '0; st_valid = 1'b0; st_sop = 1'b0; st_eop = 1'b0;
    ctrl_chipselect = 1'b0; ctrl_write = 1'b0; ctrl_read = 1'b0;
    ctrl_address = 1'b0; ctrl_data = '0;
    wmode = 2; rdy_low_seen = 1'b0;
    reset_n = 1'b1;
    #2;
    reset_n = 1'b0;
    model_reset();
    repeat (3) tick();
    chk(address == 32'h0, "rst_address", address, 0);
    chk(writedata == 32'h0, "rst_writedata", writedata, 0);
    chk(ctrl_readdata == 32'h0, "rst_readdata", ctrl_readdata, 0);
    reset_n = 1'b1;

    // basic frame
    ctrl_wr(1'b0, 32'h100);
    ctrl_wr(1'b1, 32'h1);
    send_ctrl(16'd4, 16'd2, 3);
    wlog.delete();
    send_video(8, 1'b1, 24'h000001, 1'b0);
    wait_drain();
    chk(wlog.size() == 8, "t1_count", 64'(wlog.size()), 8);
    if (wlog.size() >= 8) begin
      chk(wlog[0] == {32'h100, 32'h1}, "t1_first", wlog[0], {32'h100, 32'h1});
      chk(wlog[7] == {32'h107, 32'h8}, "t1_last", wlog[7], {32'h107, 32'h8});
    end
    check_status();

    // slow memory: backpressure on the stream
    wmode = 1; rdy_low_seen = 1'b0; wlog.delete();
    send_video(8, 1'b0, 24'h0, 1'b0);
    wait_drain();
    chk(rdy_low_seen == 1'b1, "t2_ready_dropped", 64'(rdy_low_seen), 1);
    chk(wlog.size() == 8, "t2_count", 64'(wlog.size()), 8);
    wmode = 0;

    // short frame, then a full frame from base again
    wlog.delete();
    send_video(5, 1'b1, 24'h000010, 1'b0);
    wait_drain();
    chk(wlog.size() == 5, "t3_short_count", 64'(wlog.size()), 5);
    send_video(8, 1'b0, 24'h0, 1'b0);
    wait_drain();
    chk(wlog.size() == 13, "t3_total", 64'(wlog.size()), 13);
    if (wlog.size() >= 6) chk(wlog[5][63:32] == 32'h100, "t3_restart_base", wlog[5][63:32], 32'h100);
    check_status();

    // unknown packet type
    wlog.delete();
    send_other(4'd7, 10);
    wait_drain();
    chk(wlog.size() == 0, "t4_drop", 64'(wlog.size()), 0);
    send_video(8, 1'b0, 24'h0, 1'b0);
    wait_drain();
    chk(wlog.size() == 8, "t4_after", 64'(wlog.size()), 8);

    // disabled
    ctrl_wr(1'b1, 32'h0);
    wlog.delete(); rdy_low_seen = 1'b0;
    send_video(8, 1'b0, 24'h0, 1'b0);
    wait_drain();
    chk(wlog.size() == 0, "t5_disabled", 64'(wlog.size()), 0);
    chk(rdy_low_seen == 1'b0, "t5_ready_high", 64'(rdy_low_seen), 0);
    ctrl_wr(1'b1, 32'h1);

    // truncated control packet, then excess pixels
    send_ctrl(16'd6, 16'd3, 2);
    wlog.delete();
    send_video(11, 1'b0, 24'h0, 1'b0);
    wait_drain();
    chk(wlog.size() == 8, "t6_excess", 64'(wlog.size()), 8);

    // disable while the FIFO still holds pixels
    wmode = 1; wlog.delete();
    send_video(8, 1'b0, 24'h0, 1'b0);
    ctrl_wr(1'b1, 32'h0);
    wait_drain();
    chk(wlog.size() == 8, "t7_drain", 64'(wlog.size()), 8);
    ctrl_wr(1'b1, 32'h1);
    wmode = 0;

    // abort by a new sop
    wlog.delete();
    send_video(3, 1'b0, 24'h0, 1'b1);
    send_video(8, 1'b0, 24'h0, 1'b0);
    wait_drain();
    chk(wlog.size() == 11, "t8_abort", 64'(wlog.size()), 11);
    if (wlog.size() >= 4) chk(wlog[3][63:32] == m_base, "t8_new_base", wlog[3][63:32], m_base);

    // random traffic
    for (int it = 0; it < 40; it++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 2)       send_ctrl(16'($urandom_range(1, 5)), 16'($urandom_range(1, 3)), $urandom_range(1, 4));
      else if (sel == 2) send_other(4'($urandom_range(1, 14)), $urandom_range(1, 5));
      else if (sel == 3) ctrl_wr(1'b0, $urandom);
      else if (sel == 4) ctrl_wr(1'b1, 32'($urandom_range(0, 3) != 0));
      else               send_video($urandom_range(1, 12), 1'b0, 24'h0, $urandom_range(0, 4) == 0);
    end
    ctrl_wr(1'b1, 32'h1);
    send_ctrl(16'd4, 16'd2, 3);
    send_video(8, 1'b0, 24'h0, 1'b0);
    wait_drain();
    check_status();

    // reset while a write is held by waitrequest
    ctrl_wr(1'b0, 32'h300);
    wmode = 3;
    send_video(3, 1'b0, 24'h0, 1'b1);
    repeat (3) tick();
    chk(write == 1'b1, "t10_held", 64'(write), 1);
    reset_n = 1'b0;
    model_reset();
    #1;
    chk(write == 1'b0, "t10_rst_write", 64'(write), 0);
    chk(address == 32'h0, "t10_rst_addr", address, 0);
    chk(st_ready == 1'b0, "t10_rst_ready", 64'(st_ready), 0);
    wmode = 0;
    repeat (2) tick();
    reset_n = 1'b1;
    ctrl_wr(1'b0, 32'h300);
    ctrl_wr(1'b1, 32'h1);
    send_ctrl(16'd4, 16'd2, 3);
    wlog.delete();
    send_video(8, 1'b0, 24'h0, 1'b0);
    wait_drain();
    chk(wlog.size() == 8, "t10_count", 64'(wlog.size()), 8);
    if (wlog.size() >= 1) chk(wlog[0][63:32] == 32'h300, "t10_base", wlog[0][63:32], 32'h300);
    check_status();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vip_frame_writer.md
VIP_FRAME_WRITER -- requirements
Module: vip_frame_writer

Interface
REQ-001 SHALL have parameter VIDEO_W, default 1024, meaning frame width used until a control packet is received.
REQ-002 SHALL have parameter VIDEO_H, default 768, meaning frame height used until a control packet is received.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning pixel buffer entries (power of 2, >=4).
REQ-004 SHALL have one clock and asynchronous active-low reset: clk  in  1  sole clock, rising edge; reset_n  in  1  asynchronous, active-low.
REQ-005 SHALL have ports st_data in 24, st_valid in 1, st_sop in 1, st_eop in 1, st_ready out 1: Avalon-ST Video sink, ready latency 1.
REQ-006 SHALL have ports address out 32 (word address), writedata out 32, write out 1, waitrequest in 1: Avalon-MM write master.
REQ-007 SHALL have ports ctrl_chipselect in 1, ctrl_write in 1, ctrl_read in 1, ctrl_address in 1, ctrl_data in 32, ctrl_readdata out 32: control slave.

Function
REQ-008 SHALL decode packet type from st_data[3:0] of the sop beat: 0 = video, 15 = control, others = dropped.
REQ-009 SHALL use FSM states IDLE, CTRL, VIDEO, DROP; IDLE->CTRL/VIDEO/DROP on sop beat by type; any state->IDLE on eop beat.
REQ-010 SHALL, in IDLE, ignore valid non-sop beats.
REQ-011 SHALL, in CTRL, latch fields by beat index after sop: beat1 sym0..2 = w[15:12],w[11:8],w[7:4]; beat2 = w[3:0],h[15:12],h[11:8]; beat3 = h[7:4],h[3:0],interlace; sym n = st_data[8n+3:8n].
REQ-012 SHALL commit new width/height only when beat3 is received; a control packet ending earlier leaves them unchanged.
REQ-013 SHALL sample enable at the video sop beat; if 0, treat the packet as DROP.
REQ-014 SHALL, in VIDEO, push each valid beat as {8'h00, st_data} into the FIFO while pixel_cnt < width*height; excess pixels discarded.
REQ-015 SHALL, at video sop, load the write address from base register; each MM write accepted (write & ~waitrequest) increments address by 1.
REQ-016 SHALL hold address, writedata and write stable while waitrequest is 1.
REQ-017 SHALL drive write whenever FIFO non-empty; pop on write & ~waitrequest.
REQ-018 SHALL drive st_ready = 1 when FIFO occupancy <= FIFO_DEPTH-2 (counting a same-cycle push), else 0; beats arriving one cycle after st_ready=1 are always accepted.
REQ-019 SHALL accept every valid beat in IDLE, CTRL and DROP without FIFO effect.
REQ-020 SHALL count a short frame (eop with pixel_cnt+1 < width*height) as an error; a complete frame increments frame_cnt.
REQ-021 SHALL treat a sop beat in any non-IDLE state as abort of the current packet plus start of a new one.
REQ-022 SHALL, on ctrl_chipselect & ctrl_write: address 0 writes base, address 1 writes enable = ctrl_data[0].
REQ-023 SHALL drain the FIFO to memory after enable is cleared mid-frame; only the next sop is affected.

Reset
REQ-024 SHALL on reset_n=0: state IDLE, FIFO empty, write=0, address=0, writedata=0, st_ready=0, base=0, enable=0, width=VIDEO_W, height=VIDEO_H, counters 0, ctrl_readdata=0.
REQ-025 SHALL drive st_ready=1 from the first clock after reset release.
REQ-026 SHALL abandon any in-flight MM write on reset, including one held by waitrequest.

Configuration
REQ-027 SHALL, with FRAME_WRITER_STATUS_EN defined, return on ctrl_read (registered, 1-cycle latency): address 0 = {frame_cnt[15:0], err_cnt[15:0]}, address 1 = {height[15:0], width[15:0]}.
REQ-028 SHALL, without FRAME_WRITER_STATUS_EN, omit frame_cnt/err_cnt and tie ctrl_readdata to 0.

Verification
REQ-029 SHALL cover: base=0x100, enable=1, control 4x2, video 8 pixels 0x000001..0x000008 -> writes 0x00000001..0x00000008 at addresses 0x100..0x107, frame_cnt=1.
REQ-030 SHALL cover: waitrequest high 5 cycles per write, 4x2 video -> st_ready deasserts at occupancy 3, no pixel lost or duplicated, order preserved.
REQ-031 SHALL cover: video of 5 pixels with 4x2 dims -> 5 writes, err_cnt=1, frame_cnt unchanged; next frame restarts at base.
REQ-032 SHALL cover: type-7 packet of 10 beats then 4x2 video -> no writes from type-7 packet, 8 writes after.
REQ-033 SHALL cover: enable=0 at sop, 8-pixel video -> zero writes, st_ready stays 1 throughout.
REQ-034 SHALL cover: reset_n low mid-frame with write held by waitrequest -> write=0, FIFO empty immediately; next frame writes from base.
